// File: rtl/msrv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies use shift-add and divides use restoring division, both on operand
// magnitudes with one bit per cycle, so a normal operation spends exactly XLEN
// cycles in CALC. Divide-by-zero and signed overflow resolve on a one-cycle
// fast path straight into DONE. kill_in aborts any operation and suppresses a
// pending result.
module msrv32_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            start_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] op_1_in,
    input  logic [XLEN-1:0] op_2_in,
    input  logic            kill_in,
    output logic            busy_out,
    output logic            valid_out,
    output logic [XLEN-1:0] result_out
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement negation when neg is set (XLEN wide).
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE_X) : v;
    endfunction

    // Two's-complement negation when neg is set (2*XLEN wide product).
    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE_2X) : v;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic              r_neg;
    // Multiply: {partial product high, multiplier/product low}.
    // Divide:   {partial remainder, dividend/quotient}.
    logic [2*XLEN-1:0] r_acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_last;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_div_res;
    logic [XLEN-1:0]   w_calc_res;

    assign busy_out   = (r_state == S_CALC);
    assign valid_out  = (r_state == S_DONE);
    assign result_out = r_result;
    assign w_accept   = start_in && !kill_in && (r_state != S_CALC);
    assign w_last     = (r_cnt == CNT_LAST);

    // Decode the incoming request: operand signs, magnitudes and special cases.
    always_comb begin
        w_sign_a   = 1'b0;
        w_sign_b   = 1'b0;
        w_neg      = 1'b0;
        w_fast_res = '0;
        case (funct3_in)
            3'b001: begin                        // MULH
                w_sign_a = op_1_in[XLEN-1];
                w_sign_b = op_2_in[XLEN-1];
                w_neg    = w_sign_a ^ w_sign_b;
            end
            3'b010: begin                        // MULHSU
                w_sign_a = op_1_in[XLEN-1];
                w_neg    = w_sign_a;
            end
            3'b100: begin                        // DIV
                w_sign_a = op_1_in[XLEN-1];
                w_sign_b = op_2_in[XLEN-1];
                w_neg    = w_sign_a ^ w_sign_b;
            end
            3'b110: begin                        // REM
                w_sign_a = op_1_in[XLEN-1];
                w_sign_b = op_2_in[XLEN-1];
                w_neg    = w_sign_a;
            end
            default: begin                       // MUL, MULHU, DIVU, REMU
                w_neg    = 1'b0;
            end
        endcase
        w_mag_a    = cond_neg(op_1_in, w_sign_a);
        w_mag_b    = cond_neg(op_2_in, w_sign_b);
        w_div_zero = funct3_in[2] && (op_2_in == '0);
        w_ovf      = ((funct3_in == 3'b100) || (funct3_in == 3'b110)) &&
                     (op_1_in == MIN_NEG) && (op_2_in == '1);
        w_fast     = w_div_zero || w_ovf;
        if (w_div_zero) begin
            w_fast_res = funct3_in[1] ? op_1_in : '1;
        end else if (w_ovf) begin
            w_fast_res = funct3_in[1] ? '0 : op_1_in;
        end
    end

    // One iteration of shift-add or restoring division, plus final result select.
    always_comb begin
        w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_ge     = (w_rem_sh >= {1'b0, r_opb});
        // When w_ge holds the true difference is below 2^XLEN, so the low bits suffice.
        w_diff   = w_rem_sh[XLEN-1:0] - r_opb;
        if (r_funct3[2]) begin
            w_acc_nxt = {(w_ge ? w_diff : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
        end else begin
            w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
        end
        w_prod     = cond_neg2(w_acc_nxt, r_neg);
        w_mul_res  = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        w_div_res  = cond_neg(r_funct3[1] ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0], r_neg);
        w_calc_res = r_funct3[2] ? w_div_res : w_mul_res;
    end

    // Next-state logic; kill overrides everything, including a same-cycle start.
    always_comb begin
        w_state_nxt = r_state;
        if (kill_in) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    if (w_last) w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
                    else          w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) r_state <= S_IDLE;
        else                      r_state <= w_state_nxt;
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else if (kill_in) begin
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_funct3 <= funct3_in;
            r_neg    <= w_neg;
            r_opb    <= funct3_in[2] ? w_mag_b : w_mag_a;
            r_acc    <= {{XLEN{1'b0}}, (funct3_in[2] ? w_mag_a : w_mag_b)};
            r_cnt    <= '0;
            if (w_fast) r_result <= w_fast_res;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nxt;
            if (w_last) begin
                r_cnt    <= '0;
                r_result <= w_calc_res;
            end else begin
                r_cnt    <= r_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_msrv32_muldiv_unit.sv
// Scoreboard bench for msrv32_muldiv_unit: the stimulus pushes the expected
// result and its due cycle, a forked monitor pops and compares on valid_out.
module tb_msrv32_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_in = 1'b0;
    logic            kill_in = 1'b0;
    logic [2:0]      funct3_in = 3'd0;
    logic [XLEN-1:0] op_1_in = '0;
    logic [XLEN-1:0] op_2_in = '0;
    logic            busy_out;
    logic            valid_out;
    logic [XLEN-1:0] result_out;

    msrv32_muldiv_unit #(.XLEN(XLEN)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .start_in             (start_in),
        .funct3_in            (funct3_in),
        .op_1_in              (op_1_in),
        .op_2_in              (op_2_in),
        .kill_in              (kill_in),
        .busy_out             (busy_out),
        .valid_out            (valid_out),
        .result_out           (result_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int unsigned due;
        logic [2:0]  f;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          busy_cnt = 0;
    logic [31:0] last_res = '0;
    logic [31:0] prev_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && b == 32'd0) ||
               ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference results from the RV32M definitions using 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [31:0] r;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0)   r = '1;
                else if (ovf) r = a;
                else          begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0)   r = a;
                else if (ovf) r = '0;
                else          begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Present a request in the current cycle; it is accepted on the next edge.
    task automatic issue_now(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        exp_t e;
        start_in  = 1'b1;
        funct3_in = f;
        op_1_in   = a;
        op_2_in   = b;
        @(posedge clk);
        #1;
        e.res = exp;
        e.due = cyc + (is_fast(f, a, b) ? 0 : XLEN);
        e.f   = f;
        sb_q.push_back(e);
        prev_exp  = exp;
        start_in  = 1'b0;
        funct3_in = 3'($urandom);
        op_1_in   = $urandom;
        op_2_in   = $urandom;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        @(negedge clk);
        issue_now(f, a, b, exp);
    endtask

    // Wait until the scoreboard is empty; returns inside the DONE cycle.
    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) return;
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout pending=%0d expected=0", sb_q.size());
        sb_q.delete();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_res = '0;
            end else begin
                if (busy_out) busy_cnt++;
                if (valid_out) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid result=%h expected=no_valid", result_out);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("result_f%0d", e.f), result_out, e.res);
                        checks++;
                        if (cyc != e.due) begin
                            failures++;
                            $display("FAIL latency_f%0d actual_cycle=%0d expected_cycle=%0d",
                                     e.f, cyc, e.due);
                        end
                        last_res = e.res;
                    end
                end else begin
                    chk("hold", result_out, last_res);
                end
            end
        end
    endtask

    initial begin
        int          b0;
        logic [31:0] keep;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy_out}, 32'd0);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_result", result_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiply latency and busy duration
        b0 = busy_cnt;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        drain();
        chk("mul_busy_cycles", 32'(busy_cnt - b0), 32'd32);

        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); drain();
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000); drain();
        issue(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF); drain();

        issue(3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA); drain();
        issue(3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE); drain();
        issue(3'd5, 32'd100, 32'd7, 32'd14); drain();
        issue(3'd7, 32'd100, 32'd7, 32'd2);  drain();

        // Fast path cases
        a = $urandom;
        issue(3'd5, a, 32'd0, 32'hFFFF_FFFF); drain();
        issue(3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678); drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000); drain();

        // Kill mid-CALC, then a new multiply the following cycle
        keep = prev_exp;
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        repeat (10) @(negedge clk);
        kill_in = 1'b1;
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        kill_in = 1'b0;
        chk("kill_busy", {31'b0, busy_out}, 32'd0);
        chk("kill_valid", {31'b0, valid_out}, 32'd0);
        chk("kill_result_kept", result_out, keep);
        issue_now(3'd0, 32'd3, 32'd4, 32'd12);
        drain();

        // Kill on the final CALC cycle suppresses the DONE pulse
        keep = prev_exp;
        issue(3'd0, 32'd5, 32'd6, 32'd30);
        repeat (XLEN) @(negedge clk);
        kill_in = 1'b1;
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        kill_in = 1'b0;
        chk("late_kill_valid", {31'b0, valid_out}, 32'd0);
        chk("late_kill_result", result_out, keep);

        // Kill wins over a simultaneous start
        @(negedge clk);
        start_in  = 1'b1;
        kill_in   = 1'b1;
        funct3_in = 3'd0;
        op_1_in   = 32'd9;
        op_2_in   = 32'd9;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        kill_in  = 1'b0;
        chk("kill_start_busy", {31'b0, busy_out}, 32'd0);
        chk("kill_start_valid", {31'b0, valid_out}, 32'd0);

        // Reset mid-CALC
        a = $urandom;
        b = $urandom;
        issue(3'd1, a, b, model(3'd1, a, b));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'b0, busy_out}, 32'd0);
        chk("midrst_valid", {31'b0, valid_out}, 32'd0);
        chk("midrst_result", result_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start during CALC is ignored; back-to-back issue from DONE
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        repeat (5) @(negedge clk);
        start_in  = 1'b1;
        funct3_in = 3'd0;
        op_1_in   = 32'd11;
        op_2_in   = 32'd13;
        @(negedge clk);
        start_in  = 1'b0;
        drain();
        issue_now(3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        drain();
        issue_now(3'd7, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        drain();
        issue_now(3'd0, 32'd3, 32'd4, 32'd12);
        drain();
        repeat (5) @(negedge clk);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if ($urandom_range(0, 1) == 1) issue_now(f, a, b, model(f, a, b));
            else                           issue(f, a, b, model(f, a, b));
            drain();
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
